// File: rtl/scene_renderer_pkg.sv
// Shared geometry, region codes, layer priority and small index helpers
// for the scene renderer.
package scene_renderer_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BIRD_W   = 34;
  localparam int BIRD_H   = 24;
  localparam int PIPE_W   = 52;
  localparam int PIPE_GAP = 120;
  localparam int CAP_H    = 26;
  localparam int GROUND_Y = 400;
  localparam int TILE_W   = 28;

  localparam logic [11:0]        SKY_RGB  = 12'h7CE;
  localparam logic signed [7:0]  TILT_DEG = 8'sd15;

  localparam logic [1:0] REGION_BODY   = 2'd0;
  localparam logic [1:0] REGION_CAP    = 2'd1;
  localparam logic [1:0] REGION_GROUND = 2'd2;

  typedef enum logic [1:0] {
    LAYER_SKY  = 2'd0,
    LAYER_TILE = 2'd1,
    LAYER_BIRD = 2'd2
  } layer_e;

  // Wide enough that a 10-bit pixel minus any 16-bit position never wraps.
  typedef logic signed [17:0] coord_t;

  typedef struct packed {
    logic signed [15:0] stage_shift;
    logic [1:0]         bird_status;
    logic signed [15:0] bird_x;
    logic signed [15:0] bird_y;
    logic signed [7:0]  bird_angle;
    logic [2:0][15:0]   pipe_x;
    logic [2:0][15:0]   pipe_y;
  } game_state_t;

  function automatic logic [1:0] flap_idx(input logic [1:0] status);
    return (status == 2'd3) ? 2'd1 : status;
  endfunction

  function automatic logic [1:0] tilt_idx(input logic signed [7:0] angle);
    logic [1:0] t;
    if (angle > TILT_DEG)       t = 2'd1;
    else if (angle < -TILT_DEG) t = 2'd2;
    else                        t = 2'd0;
    return t;
  endfunction

endpackage

// File: rtl/scene_renderer_if.sv
// Pixel stream, game state, sprite/tile ROM and output signals of the renderer.
interface scene_renderer_if;

  logic               new_frame;
  logic               pix_valid;
  logic [9:0]         pix_x;
  logic [9:0]         pix_y;
  logic signed [15:0] stage_shift;
  logic [1:0]         bird_status;
  logic signed [15:0] bird_pos_x;
  logic signed [15:0] bird_pos_y;
  logic signed [7:0]  bird_angle;
  logic signed [15:0] pipe1_pos_x;
  logic signed [15:0] pipe2_pos_x;
  logic signed [15:0] pipe3_pos_x;
  logic signed [15:0] pipe1_pos_y;
  logic signed [15:0] pipe2_pos_y;
  logic signed [15:0] pipe3_pos_y;
  logic [14:0]        spr_addr;
  logic [12:0]        spr_data;
  logic [14:0]        tile_addr;
  logic [11:0]        tile_data;
  logic               out_valid;
  logic [11:0]        out_rgb;

  modport master (
    output new_frame, pix_valid, pix_x, pix_y, stage_shift, bird_status,
           bird_pos_x, bird_pos_y, bird_angle,
           pipe1_pos_x, pipe2_pos_x, pipe3_pos_x,
           pipe1_pos_y, pipe2_pos_y, pipe3_pos_y,
           spr_data, tile_data,
    input  spr_addr, tile_addr, out_valid, out_rgb
  );

  modport slave (
    input  new_frame, pix_valid, pix_x, pix_y, stage_shift, bird_status,
           bird_pos_x, bird_pos_y, bird_angle,
           pipe1_pos_x, pipe2_pos_x, pipe3_pos_x,
           pipe1_pos_y, pipe2_pos_y, pipe3_pos_y,
           spr_data, tile_data,
    output spr_addr, tile_addr, out_valid, out_rgb
  );

endinterface

// File: rtl/scene_renderer_rect_hit.sv
// Signed point-in-rectangle test; combinational, returns hit and offsets from the corner.
// With CHECK_Y=0 only the column range is tested (vertical strips such as pipes).
module rect_hit
  import scene_renderer_pkg::*;
#(
  parameter int   W       = 1,
  parameter int   H       = 1,
  parameter logic CHECK_Y = 1'b1
) (
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic signed [15:0] rect_x,
  input  logic signed [15:0] rect_y,
  output logic               hit,
  output coord_t             dx,
  output coord_t             dy
);

  localparam coord_t W_C = coord_t'(W);
  localparam coord_t H_C = coord_t'(H);

  logic x_in;
  logic y_in;

  assign dx   = $signed({8'd0, x}) - $signed({{2{rect_x[15]}}, rect_x});
  assign dy   = $signed({8'd0, y}) - $signed({{2{rect_y[15]}}, rect_y});
  assign x_in = !dx[17] && (dx < W_C);
  assign y_in = !dy[17] && (dy < H_C);
  assign hit  = x_in && (!CHECK_Y || y_in);

endmodule

// File: rtl/scene_renderer.sv
// Renders bird, pipes, ground and sky from a per-frame shadow of the game state.
// Pixel in at N, RGB out at N+3; no backpressure, pix_valid bubbles give out_valid=0.
module scene_renderer
  import scene_renderer_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  scene_renderer_if.slave bus
);

  localparam coord_t GAP_C = coord_t'(PIPE_GAP);
  localparam coord_t CAP_C = coord_t'(CAP_H);
  localparam logic signed [15:0] SHIFT_MAX = 16'(TILE_W - 1);

  game_state_t shadow_q, shadow_d, live_state;
  logic        nf_dly_q, nf_dly_d, latch_en_q, latch_en_d;
  logic [14:0] spr_addr_q, spr_addr_d, tile_addr_q, tile_addr_d;
  logic        s1_vld_q, s1_vld_d, s1_bird_q, s1_bird_d, s1_tile_q, s1_tile_d;
  logic        s2_vld_q, s2_vld_d, s2_bird_q, s2_bird_d, s2_tile_q, s2_tile_d;
  logic        out_valid_q, out_valid_d;
  logic [11:0] out_rgb_q, out_rgb_d;

  logic       bird_hit;
  coord_t     bird_dx, bird_dy;
  logic [2:0] pipe_col;
  coord_t     pipe_dx [3];
  coord_t     pipe_dy [3];

  coord_t     cap_rel;
  logic       pipe_any;
  logic [1:0] pipe_region;
  logic [6:0] pipe_row;
  logic [5:0] pipe_col_idx;
  logic       gnd_hit;
  logic [6:0] gnd_row;
  logic [4:0] gnd_xmod, gnd_shift;
  logic [5:0] gnd_sum, gnd_col;
  layer_e     layer;
  logic [11:0] comp_rgb;
  logic        unused_bits;

  always_comb begin
    live_state             = '0;
    live_state.stage_shift = bus.stage_shift;
    live_state.bird_status = bus.bird_status;
    live_state.bird_x      = bus.bird_pos_x;
    live_state.bird_y      = bus.bird_pos_y;
    live_state.bird_angle  = bus.bird_angle;
    live_state.pipe_x      = {bus.pipe3_pos_x, bus.pipe2_pos_x, bus.pipe1_pos_x};
    live_state.pipe_y      = {bus.pipe3_pos_y, bus.pipe2_pos_y, bus.pipe1_pos_y};
  end

  // Two-cycle delay lets producers that update just after new_frame settle.
  always_comb begin
    nf_dly_d   = bus.new_frame;
    latch_en_d = nf_dly_q;
    shadow_d   = latch_en_q ? live_state : shadow_q;
  end

  rect_hit #(.W(BIRD_W), .H(BIRD_H), .CHECK_Y(1'b1)) u_bird (
    .x(bus.pix_x), .y(bus.pix_y),
    .rect_x(shadow_q.bird_x), .rect_y(shadow_q.bird_y),
    .hit(bird_hit), .dx(bird_dx), .dy(bird_dy)
  );

  for (genvar k = 0; k < 3; k++) begin : g_pipe
    rect_hit #(.W(PIPE_W), .H(1), .CHECK_Y(1'b0)) u_pipe (
      .x(bus.pix_x), .y(bus.pix_y),
      .rect_x(shadow_q.pipe_x[k]), .rect_y(shadow_q.pipe_y[k]),
      .hit(pipe_col[k]), .dx(pipe_dx[k]), .dy(pipe_dy[k])
    );
  end

  // Scan from the highest index down so the lowest-index pipe overrides.
  always_comb begin
    pipe_any     = 1'b0;
    pipe_region  = REGION_BODY;
    pipe_row     = '0;
    pipe_col_idx = '0;
    cap_rel      = '0;
    for (int k = 2; k >= 0; k--) begin
      if (pipe_col[k] && (pipe_dy[k][17] || pipe_dy[k] >= GAP_C)) begin
        pipe_any     = 1'b1;
        pipe_col_idx = pipe_dx[k][5:0];
        pipe_region  = REGION_BODY;
        pipe_row     = '0;
        if (pipe_dy[k][17] && pipe_dy[k] >= -CAP_C) begin
          cap_rel     = pipe_dy[k] + CAP_C;
          pipe_region = REGION_CAP;
          pipe_row    = cap_rel[6:0];
        end else if (pipe_dy[k] >= GAP_C && pipe_dy[k] < GAP_C + CAP_C) begin
          cap_rel     = pipe_dy[k] - GAP_C;
          pipe_region = REGION_CAP;
          pipe_row    = cap_rel[6:0];
        end
      end
    end
  end

  always_comb begin
    gnd_hit   = bus.pix_y >= 10'(GROUND_Y);
    gnd_row   = 7'(bus.pix_y - 10'(GROUND_Y));
    gnd_xmod  = 5'(bus.pix_x % 10'(TILE_W));
    gnd_shift = (shadow_q.stage_shift < 16'sd0 || shadow_q.stage_shift > SHIFT_MAX)
                ? 5'd0 : shadow_q.stage_shift[4:0];
    gnd_sum   = {1'b0, gnd_xmod} + {1'b0, gnd_shift};
    gnd_col   = (gnd_sum >= 6'(TILE_W)) ? gnd_sum - 6'(TILE_W) : gnd_sum;
  end

  always_comb begin
    s1_vld_d   = bus.pix_valid;
    s1_bird_d  = bird_hit;
    s1_tile_d  = gnd_hit || pipe_any;
    spr_addr_d = {tilt_idx(shadow_q.bird_angle), flap_idx(shadow_q.bird_status),
                  bird_dy[4:0], bird_dx[5:0]};
    if (gnd_hit)       tile_addr_d = {REGION_GROUND, gnd_row, gnd_col};
    else if (pipe_any) tile_addr_d = {pipe_region, pipe_row, pipe_col_idx};
    else               tile_addr_d = '0;
    s2_vld_d  = s1_vld_q;
    s2_bird_d = s1_bird_q;
    s2_tile_d = s1_tile_q;
  end

  always_comb begin
    if (s2_bird_q && bus.spr_data[12]) layer = LAYER_BIRD;
    else if (s2_tile_q)                layer = LAYER_TILE;
    else                               layer = LAYER_SKY;
    case (layer)
      LAYER_BIRD: comp_rgb = bus.spr_data[11:0];
      LAYER_TILE: comp_rgb = bus.tile_data;
      default:    comp_rgb = SKY_RGB;
    endcase
    out_valid_d = s2_vld_q;
    out_rgb_d   = s2_vld_q ? comp_rgb : out_rgb_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      shadow_q    <= '0;
      nf_dly_q    <= 1'b0;
      latch_en_q  <= 1'b0;
      spr_addr_q  <= '0;
      tile_addr_q <= '0;
      s1_vld_q    <= 1'b0;
      s1_bird_q   <= 1'b0;
      s1_tile_q   <= 1'b0;
      s2_vld_q    <= 1'b0;
      s2_bird_q   <= 1'b0;
      s2_tile_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_rgb_q   <= '0;
    end else begin
      shadow_q    <= shadow_d;
      nf_dly_q    <= nf_dly_d;
      latch_en_q  <= latch_en_d;
      spr_addr_q  <= spr_addr_d;
      tile_addr_q <= tile_addr_d;
      s1_vld_q    <= s1_vld_d;
      s1_bird_q   <= s1_bird_d;
      s1_tile_q   <= s1_tile_d;
      s2_vld_q    <= s2_vld_d;
      s2_bird_q   <= s2_bird_d;
      s2_tile_q   <= s2_tile_d;
      out_valid_q <= out_valid_d;
      out_rgb_q   <= out_rgb_d;
    end
  end

  assign bus.spr_addr  = spr_addr_q;
  assign bus.tile_addr = tile_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_rgb   = out_rgb_q;

  assign unused_bits = ^{bird_dx[17:6], bird_dy[17:5], pipe_dx[0][17:6],
                         pipe_dx[1][17:6], pipe_dx[2][17:6], cap_rel[17:7]};

endmodule

// File: tb/tb_scene_renderer.sv
// Directed bench for scene_renderer: reset, shadow latch timing, pipe/ground/bird
// geometry and compositing, with behavioural sprite and tile ROMs.
module tb_scene_renderer;

  logic clk;
  logic rstn;
  logic spr_opaque;
  int   errors;
  int   checks;

  logic [14:0] got_spr;
  logic [14:0] got_tile;
  logic        got_v1, got_v2, got_v3;
  logic [11:0] got_rgb;

  scene_renderer_if bus ();

  scene_renderer dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROMs: data is a fixed scramble of the address, so expected colours follow from expected addresses.
  always @(posedge clk) begin
    bus.spr_data  <= {spr_opaque, bus.spr_addr[11:0] ^ 12'h5A5};
    bus.tile_data <= bus.tile_addr[11:0] ^ 12'hC33;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_state(input int sh, input int st, input int bx, input int by,
                           input int ang, input int p1x, input int p1y, input int p2x,
                           input int p2y, input int p3x, input int p3y);
    bus.stage_shift = 16'(sh);
    bus.bird_status = 2'(st);
    bus.bird_pos_x  = 16'(bx);
    bus.bird_pos_y  = 16'(by);
    bus.bird_angle  = 8'(ang);
    bus.pipe1_pos_x = 16'(p1x);
    bus.pipe1_pos_y = 16'(p1y);
    bus.pipe2_pos_x = 16'(p2x);
    bus.pipe2_pos_y = 16'(p2y);
    bus.pipe3_pos_x = 16'(p3x);
    bus.pipe3_pos_y = 16'(p3y);
  endtask

  // new_frame pulse, state changes one cycle later, shadows updated after the third edge.
  task automatic do_frame(input int sh, input int st, input int bx, input int by,
                          input int ang, input int p1x, input int p1y, input int p2x,
                          input int p2y, input int p3x, input int p3y);
    bus.new_frame = 1'b1;
    tick();
    bus.new_frame = 1'b0;
    set_state(sh, st, bx, by, ang, p1x, p1y, p2x, p2y, p3x, p3y);
    tick();
    tick();
  endtask

  task automatic run_pix(input logic [9:0] x, input logic [9:0] y);
    bus.pix_x     = x;
    bus.pix_y     = y;
    bus.pix_valid = 1'b1;
    tick();
    bus.pix_valid = 1'b0;
    got_spr  = bus.spr_addr;
    got_tile = bus.tile_addr;
    got_v1   = bus.out_valid;
    tick();
    got_v2 = bus.out_valid;
    tick();
    got_v3  = bus.out_valid;
    got_rgb = bus.out_rgb;
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    spr_opaque    = 1'b0;
    rstn          = 1'b0;
    bus.new_frame = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_x     = 10'd10;
    bus.pix_y     = 10'd10;
    set_state(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held while pix_valid toggles
    for (int i = 0; i < 6; i++) begin
      bus.pix_valid = i[0];
      tick();
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    end
    check("reset_out_rgb", 32'(bus.out_rgb), 32'h0);
    check("reset_spr_addr", 32'(bus.spr_addr), 32'h0);
    check("reset_tile_addr", 32'(bus.tile_addr), 32'h0);
    rstn          = 1'b1;
    bus.pix_valid = 1'b0;
    tick();

    // Zeroed shadows: bird at (0,0) covers (10,10) but is transparent -> sky
    run_pix(10'd10, 10'd10);
    check("lat_v1", 32'(got_v1), 32'd0);
    check("lat_v2", 32'(got_v2), 32'd0);
    check("lat_v3", 32'(got_v3), 32'd1);
    check("first_spr_addr", 32'(got_spr), 32'h28A);
    check("first_tile_addr", 32'(got_tile), 32'h0);
    check("first_rgb", 32'(got_rgb), 32'h7CE);
    tick();
    check("bubble_valid", 32'(bus.out_valid), 32'd0);
    check("bubble_rgb_hold", 32'(bus.out_rgb), 32'h7CE);

    // Shadow latch: state changes the cycle after new_frame
    bus.new_frame = 1'b1;
    tick();
    bus.new_frame = 1'b0;
    set_state(0, 0, 600, 460, 0, 100, 150, -200, 0, -200, 0);
    tick();
    run_pix(10'd100, 10'd140);
    check("inflight_old_tile", 32'(got_tile), 32'h0);
    check("inflight_old_rgb", 32'(got_rgb), 32'h7CE);
    run_pix(10'd100, 10'd140);
    check("latched_cap_tile", 32'(got_tile), 32'h2400);
    check("latched_cap_rgb", 32'(got_rgb), 32'h833);

    // Empty scene
    do_frame(0, 0, 600, 460, 0, -200, 0, -200, 0, -200, 0);
    run_pix(10'd10, 10'd10);
    check("empty_tile", 32'(got_tile), 32'h0);
    check("empty_rgb", 32'(got_rgb), 32'h7CE);

    // Pipe edges, pipe2 at (-10,200)
    do_frame(0, 0, 600, 460, 0, -200, 0, -10, 200, -200, 0);
    run_pix(10'd41, 10'd0);
    check("pipe_last_col_tile", 32'(got_tile), 32'h033);
    check("pipe_last_col_rgb", 32'(got_rgb), 32'hC00);
    run_pix(10'd42, 10'd0);
    check("pipe_past_col_tile", 32'(got_tile), 32'h0);
    check("pipe_past_col_rgb", 32'(got_rgb), 32'h7CE);
    run_pix(10'd0, 10'd200);
    check("pipe_gap_top_rgb", 32'(got_rgb), 32'h7CE);
    run_pix(10'd0, 10'd320);
    check("pipe_low_cap0_tile", 32'(got_tile), 32'h200A);
    check("pipe_low_cap0_rgb", 32'(got_rgb), 32'hC39);
    run_pix(10'd0, 10'd199);
    check("pipe_up_cap25_tile", 32'(got_tile), 32'h264A);
    check("pipe_up_cap25_rgb", 32'(got_rgb), 32'hA79);
    run_pix(10'd0, 10'd346);
    check("pipe_below_cap_tile", 32'(got_tile), 32'h00A);

    // Ground scroll, with pipe1 also covering column 1 to test ground priority
    do_frame(27, 0, 600, 460, 0, -10, 0, -200, 0, -200, 0);
    run_pix(10'd1, 10'd400);
    check("gnd_wrap_tile", 32'(got_tile), 32'h4000);
    check("gnd_wrap_rgb", 32'(got_rgb), 32'hC33);
    run_pix(10'd639, 10'd479);
    check("gnd_corner_tile", 32'(got_tile), 32'h53D6);
    check("gnd_corner_rgb", 32'(got_rgb), 32'hFE5);
    run_pix(10'd1, 10'd399);
    check("above_gnd_pipe_tile", 32'(got_tile), 32'h00B);
    do_frame(40, 0, 600, 460, 0, -10, 0, -200, 0, -200, 0);
    run_pix(10'd1, 10'd400);
    check("gnd_shift_big_tile", 32'(got_tile), 32'h4001);
    check("gnd_shift_big_rgb", 32'(got_rgb), 32'hC32);
    do_frame(-5, 0, 600, 460, 0, -10, 0, -200, 0, -200, 0);
    run_pix(10'd1, 10'd400);
    check("gnd_shift_neg_tile", 32'(got_tile), 32'h4001);

    // Bird over pipe cap; pipe2 body also hits but pipe1 wins
    do_frame(0, 3, 0, 0, -60, 0, -120, 0, -200, -200, 0);
    spr_opaque = 1'b0;
    run_pix(10'd5, 10'd5);
    check("bird_spr_addr", 32'(got_spr), 32'h4945);
    check("bird_pipe_prio_tile", 32'(got_tile), 32'h2145);
    check("bird_clear_rgb", 32'(got_rgb), 32'hD76);
    spr_opaque = 1'b1;
    run_pix(10'd5, 10'd5);
    check("bird_opaque_rgb", 32'(got_rgb), 32'hCE0);

    // Tilt thresholds and flap mapping
    do_frame(0, 2, 0, 0, 16, -200, 0, -200, 0, -200, 0);
    run_pix(10'd5, 10'd5);
    check("tilt_up_addr", 32'(got_spr), 32'h3145);
    do_frame(0, 0, 0, 0, 15, -200, 0, -200, 0, -200, 0);
    run_pix(10'd5, 10'd5);
    check("tilt_pos_edge_addr", 32'(got_spr), 32'h0145);
    do_frame(0, 1, 0, 0, -15, -200, 0, -200, 0, -200, 0);
    run_pix(10'd5, 10'd5);
    check("tilt_neg_edge_addr", 32'(got_spr), 32'h0945);

    // Reset mid-pipeline flushes and zeroes shadows
    bus.pix_x     = 10'd5;
    bus.pix_y     = 10'd5;
    bus.pix_valid = 1'b1;
    tick();
    bus.pix_valid = 1'b0;
    tick();
    rstn = 1'b0;
    tick();
    check("midreset_valid", 32'(bus.out_valid), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("postreset_idle_valid", 32'(bus.out_valid), 32'd0);
    run_pix(10'd10, 10'd10);
    check("postreset_v3", 32'(got_v3), 32'd1);
    check("postreset_spr_addr", 32'(got_spr), 32'h28A);
    check("postreset_rgb", 32'(got_rgb), 32'h72F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
